// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit: turns one execute-stage memory request into a single word-bus access
// and returns byte-aligned, extended load data (or an error) through a valid/ready result port.
module ysyx_23060201_lsu #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_ren,
  input  logic                  in_wen,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [7:0]            in_rmask,
  input  logic [7:0]            in_wmask,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rdata,
  output logic                  out_err,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_wstrb,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_gnt,
  input  logic                  bus_rvalid,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t          state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic            sext_q, sext_d;
  logic            ren_q, ren_d;
  logic [3:0]      size_q, size_d;
  logic [1:0]      off_q, off_d;

  logic                  out_valid_d, out_err_d;
  logic [DATA_WIDTH-1:0] out_rdata_d;
  logic                  bus_req_d, bus_we_d;
  logic [ADDR_WIDTH-1:0] bus_addr_d;
  logic [3:0]            bus_wstrb_d;
  logic [DATA_WIDTH-1:0] bus_wdata_d;

  logic [3:0]            size_c;
  logic                  mask_ok_c, misalign_c;
  logic [DATA_WIDTH-1:0] shifted_c, load_c;

  assign in_ready = (state == IDLE) & ~rst;

  // Request decode: byte-lane size and legality of the incoming mask/alignment.
  assign size_c     = in_ren ? in_rmask[3:0] : in_wmask[3:0];
  assign misalign_c = ((size_c == 4'h3) && in_addr[0]) ||
                      ((size_c == 4'hF) && (in_addr[1:0] != 2'b00));

  always_comb begin
    mask_ok_c = 1'b0;
    if (in_ren) begin
      case (in_rmask)
        8'h01, 8'h03, 8'h11, 8'h13, 8'h1F: mask_ok_c = 1'b1;
        default:                           mask_ok_c = 1'b0;
      endcase
    end else begin
      case (in_wmask)
        8'h01, 8'h03, 8'h0F: mask_ok_c = 1'b1;
        default:             mask_ok_c = 1'b0;
      endcase
    end
  end

  // Load alignment and zero/sign extension of the returned word.
  assign shifted_c = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    case (size_q)
      4'h1:    load_c = {{24{sext_q & shifted_c[7]}}, shifted_c[7:0]};
      4'h3:    load_c = {{16{sext_q & shifted_c[15]}}, shifted_c[15:0]};
      default: load_c = shifted_c;
    endcase
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    sext_d      = sext_q;
    ren_d       = ren_q;
    size_d      = size_q;
    off_d       = off_q;
    out_valid_d = out_valid;
    out_err_d   = out_err;
    out_rdata_d = out_rdata;
    bus_req_d   = bus_req;
    bus_we_d    = bus_we;
    bus_addr_d  = bus_addr;
    bus_wstrb_d = bus_wstrb;
    bus_wdata_d = bus_wdata;

    case (state)
      IDLE: begin
        if (in_valid) begin
          ren_d  = in_ren;
          sext_d = in_rmask[4];
          size_d = size_c;
          off_d  = in_addr[1:0];
          if ((in_ren && in_wen) || ((in_ren || in_wen) && (!mask_ok_c || misalign_c))) begin
            state_d     = RESP;
            out_valid_d = 1'b1;
            out_err_d   = 1'b1;
            out_rdata_d = '0;
          end else if (!in_ren && !in_wen) begin
            state_d     = RESP;
            out_valid_d = 1'b1;
            out_err_d   = 1'b0;
            out_rdata_d = '0;
          end else begin
            state_d     = REQ;
            bus_req_d   = 1'b1;
            bus_we_d    = in_wen;
            bus_addr_d  = {in_addr[ADDR_WIDTH-1:2], 2'b00};
            bus_wstrb_d = size_c << in_addr[1:0];
            bus_wdata_d = in_wdata << {in_addr[1:0], 3'b000};
          end
        end
      end
      REQ: begin
        if (bus_gnt) begin
          state_d   = WAIT;
          bus_req_d = 1'b0;
          cnt_d     = '0;
        end
      end
      WAIT: begin
        if (bus_rvalid) begin
          state_d     = RESP;
          out_valid_d = 1'b1;
          out_err_d   = 1'b0;
          out_rdata_d = ren_q ? load_c : '0;
          cnt_d       = '0;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_d     = RESP;
          out_valid_d = 1'b1;
          out_err_d   = 1'b1;
          out_rdata_d = '0;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sext_q    <= 1'b0;
      ren_q     <= 1'b0;
      size_q    <= '0;
      off_q     <= '0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      out_rdata <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wstrb <= '0;
      bus_wdata <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      sext_q    <= sext_d;
      ren_q     <= ren_d;
      size_q    <= size_d;
      off_q     <= off_d;
      out_valid <= out_valid_d;
      out_err   <= out_err_d;
      out_rdata <= out_rdata_d;
      bus_req   <= bus_req_d;
      bus_we    <= bus_we_d;
      bus_addr  <= bus_addr_d;
      bus_wstrb <= bus_wstrb_d;
      bus_wdata <= bus_wdata_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// Self-checking bench for ysyx_23060201_lsu: table of single-access vectors plus
// hand-written backpressure, timeout and reset sequences.
module tb_ysyx_23060201_lsu;

  logic        clk, rst;
  logic        in_valid, in_ready, in_ren, in_wen;
  logic [31:0] in_addr, in_wdata;
  logic [7:0]  in_rmask, in_wmask;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  int checks = 0;
  int errors = 0;

  ysyx_23060201_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ren(in_ren), .in_wen(in_wen),
    .in_addr(in_addr), .in_rmask(in_rmask), .in_wmask(in_wmask), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ren, wen;
    logic [31:0] addr;
    logic [7:0]  rmask, wmask;
    logic [31:0] wdata, rdata;
    logic        nobus, err, we;
    logic [31:0] baddr;
    logic [3:0]  wstrb;
    logic [31:0] bwdata, exp_rdata;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic ren, input logic wen,
                              input logic [31:0] addr, input logic [7:0] rmask,
                              input logic [7:0] wmask, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic nobus, input logic err,
                              input logic [31:0] baddr, input logic [3:0] wstrb,
                              input logic [31:0] bwdata, input logic [31:0] exp_rdata);
    vec_t v;
    v.name = name; v.ren = ren; v.wen = wen; v.addr = addr; v.rmask = rmask;
    v.wmask = wmask; v.wdata = wdata; v.rdata = rdata; v.nobus = nobus; v.err = err;
    v.we = wen; v.baddr = baddr; v.wstrb = wstrb; v.bwdata = bwdata; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  task automatic issue(input logic ren, input logic wen, input logic [31:0] addr,
                       input logic [7:0] rmask, input logic [7:0] wmask, input logic [31:0] wdata);
    in_valid = 1'b1; in_ren = ren; in_wen = wen; in_addr = addr;
    in_rmask = rmask; in_wmask = wmask; in_wdata = wdata;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    for (int k = 0; k < 20 && !in_ready; k++) tick();
    chk({v.name, " in_ready_wait"}, {31'd0, in_ready}, 32'd1);
    issue(v.ren, v.wen, v.addr, v.rmask, v.wmask, v.wdata);
    if (v.nobus) begin
      chk({v.name, " bus_req"}, {31'd0, bus_req}, 32'd0);
      chk({v.name, " out_valid"}, {31'd0, out_valid}, 32'd1);
      chk({v.name, " out_err"}, {31'd0, out_err}, {31'd0, v.err});
      chk({v.name, " out_rdata"}, out_rdata, 32'd0);
    end else begin
      chk({v.name, " bus_req"}, {31'd0, bus_req}, 32'd1);
      chk({v.name, " bus_we"}, {31'd0, bus_we}, {31'd0, v.we});
      chk({v.name, " bus_addr"}, bus_addr, v.baddr);
      chk({v.name, " bus_wstrb"}, {28'd0, bus_wstrb}, {28'd0, v.wstrb});
      if (v.we) chk({v.name, " bus_wdata"}, bus_wdata, v.bwdata);
      chk({v.name, " in_ready_busy"}, {31'd0, in_ready}, 32'd0);
      bus_gnt = 1'b1;
      tick();
      bus_gnt = 1'b0;
      chk({v.name, " bus_req_drop"}, {31'd0, bus_req}, 32'd0);
      chk({v.name, " out_valid_early"}, {31'd0, out_valid}, 32'd0);
      bus_rvalid = 1'b1; bus_rdata = v.rdata;
      tick();
      bus_rvalid = 1'b0; bus_rdata = 32'h0;
      chk({v.name, " out_valid"}, {31'd0, out_valid}, 32'd1);
      chk({v.name, " out_err"}, {31'd0, out_err}, 32'd0);
      chk({v.name, " out_rdata"}, out_rdata, v.exp_rdata);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({v.name, " out_valid_clear"}, {31'd0, out_valid}, 32'd0);
    chk({v.name, " in_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    vecs[0]  = mk("lb_sext",   1, 0, 32'h80000003, 8'h11, 8'h00, 32'h0, 32'h80FFFFFF, 0, 0, 32'h80000000, 4'b1000, 32'h0, 32'hFFFFFF80);
    vecs[1]  = mk("lhu",       1, 0, 32'h80000002, 8'h03, 8'h00, 32'h0, 32'hBEEF1234, 0, 0, 32'h80000000, 4'b1100, 32'h0, 32'h0000BEEF);
    vecs[2]  = mk("sh",        0, 1, 32'h80000002, 8'h00, 8'h03, 32'h0000ABCD, 32'h12345678, 0, 0, 32'h80000000, 4'b1100, 32'hABCD0000, 32'h0);
    vecs[3]  = mk("lw_misal",  1, 0, 32'h80000001, 8'h1F, 8'h00, 32'h0, 32'h0, 1, 1, 32'h0, 4'h0, 32'h0, 32'h0);
    vecs[4]  = mk("lh_sext",   1, 0, 32'h80000000, 8'h13, 8'h00, 32'h0, 32'h00008001, 0, 0, 32'h80000000, 4'b0011, 32'h0, 32'hFFFF8001);
    vecs[5]  = mk("lbu",       1, 0, 32'h80000001, 8'h01, 8'h00, 32'h0, 32'h0000F500, 0, 0, 32'h80000000, 4'b0010, 32'h0, 32'h000000F5);
    vecs[6]  = mk("lw",        1, 0, 32'h80000004, 8'h1F, 8'h00, 32'h0, 32'hDEADBEEF, 0, 0, 32'h80000004, 4'b1111, 32'h0, 32'hDEADBEEF);
    vecs[7]  = mk("sb",        0, 1, 32'h80000001, 8'h00, 8'h01, 32'h123456AB, 32'h0, 0, 0, 32'h80000000, 4'b0010, 32'h3456AB00, 32'h0);
    vecs[8]  = mk("sw",        0, 1, 32'h80000008, 8'h00, 8'h0F, 32'hCAFEF00D, 32'h0, 0, 0, 32'h80000008, 4'b1111, 32'hCAFEF00D, 32'h0);
    vecs[9]  = mk("ren_wen",   1, 1, 32'h80000000, 8'h1F, 8'h0F, 32'h0, 32'h0, 1, 1, 32'h0, 4'h0, 32'h0, 32'h0);
    vecs[10] = mk("bad_mask",  1, 0, 32'h80000000, 8'h07, 8'h00, 32'h0, 32'h0, 1, 1, 32'h0, 4'h0, 32'h0, 32'h0);
    vecs[11] = mk("lh_misal",  1, 0, 32'h80000003, 8'h13, 8'h00, 32'h0, 32'h0, 1, 1, 32'h0, 4'h0, 32'h0, 32'h0);
    vecs[12] = mk("noop",      0, 0, 32'h80000000, 8'h00, 8'h00, 32'h0, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0);
    vecs[13] = mk("lb_pos",    1, 0, 32'h80000002, 8'h11, 8'h00, 32'h0, 32'h007F0000, 0, 0, 32'h80000000, 4'b0100, 32'h0, 32'h0000007F);

    rst = 1'b1; in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0; in_addr = 32'h0;
    in_rmask = 8'h0; in_wmask = 8'h0; in_wdata = 32'h0; out_ready = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    repeat (3) tick();
    chk("rst in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst bus_addr", bus_addr, 32'd0);
    chk("rst out_rdata", out_rdata, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst in_ready", {31'd0, in_ready}, 32'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Grant withheld with stray rvalid/in_valid, then result held under out_ready low.
    issue(1, 0, 32'h80000010, 8'h1F, 8'h00, 32'h0);
    in_valid = 1'b1; in_addr = 32'h80000020;
    for (int i = 0; i < 5; i++) begin
      bus_rvalid = 1'b1; bus_rdata = 32'h55555555;
      tick();
      chk("bp bus_req", {31'd0, bus_req}, 32'd1);
      chk("bp bus_addr", bus_addr, 32'h80000010);
      chk("bp bus_wstrb", {28'd0, bus_wstrb}, 32'hF);
      chk("bp in_ready", {31'd0, in_ready}, 32'd0);
    end
    bus_rvalid = 1'b0; in_valid = 1'b0;
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h11223344;
    tick();
    bus_rvalid = 1'b0;
    chk("bp out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp out_rdata", out_rdata, 32'h11223344);
    held = out_rdata;
    for (int i = 0; i < 3; i++) begin
      bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hA5A5A5A5 + 32'(i);
      tick();
      chk("bp hold out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp hold out_rdata", out_rdata, held);
      chk("bp hold in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp hold bus_req", {31'd0, bus_req}, 32'd0);
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp done out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp done in_ready", {31'd0, in_ready}, 32'd1);

    // Timeout: rvalid never arrives after grant.
    issue(1, 0, 32'h80000000, 8'h01, 8'h00, 32'h0);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("to waiting out_valid", {31'd0, out_valid}, 32'd0);
    end
    tick();
    chk("to out_valid", {31'd0, out_valid}, 32'd1);
    chk("to out_err", {31'd0, out_err}, 32'd1);
    chk("to out_rdata", out_rdata, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
    tick();
    bus_rvalid = 1'b0;
    chk("late rvalid out_valid", {31'd0, out_valid}, 32'd0);
    chk("late rvalid bus_req", {31'd0, bus_req}, 32'd0);
    chk("late rvalid in_ready", {31'd0, in_ready}, 32'd1);

    // Reset while waiting in REQ, then while in WAIT.
    issue(1, 0, 32'h80000020, 8'h1F, 8'h00, 32'h0);
    rst = 1'b1;
    #1;
    chk("rst_req in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_req bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_req in_ready", {31'd0, in_ready}, 32'd1);
    issue(1, 0, 32'h80000020, 8'h1F, 8'h00, 32'h0);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_wait bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_wait out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_wait in_ready", {31'd0, in_ready}, 32'd1);
    bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
    tick();
    bus_rvalid = 1'b0;
    chk("rst_wait late rvalid", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
